exp_flt_mch: RTL and testbench

- Parametrised multi-channel first-order exponential (IIR) low-pass filter: y += A*(x - y), per channel.
- Sits between the ADC sampler and the Clarke/Park stage.
- Accepts one unsigned offset-binary ADC frame per in_val and emits one signed filtered frame per out_val.
- A single time-shared multiplier serves all channels. Adds a runtime coefficient, bypass, init/preload and overrun detection.

---
 rtl/exp_flt_mch_pkg.sv | 38 +++
 rtl/exp_flt_core.sv | 59 +++++
 rtl/exp_flt_mch.sv | 200 ++++++++++++++++++++
 tb/tb_exp_flt_mch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exp_flt_mch_pkg.sv
// exp_flt_mch_pkg
// Shared defaults and types for the multi-channel exponential low-pass filter.
// The localparams here are the single source of truth for the default build:
//   ADC_N      channel count
//   ADC_W      ADC sample width (unsigned offset-binary)
//   ADC_H      ADC mid-scale offset, 2^(ADC_W-1)
//   EXP_FLT_W  signed filter state / output width
//   EXP_FLT_A  unsigned coefficient width (A = coef_a / 2^EXP_FLT_A)
package exp_flt_mch_pkg;

  localparam int ADC_N     = 2;
  localparam int ADC_W     = 12;
  localparam int ADC_H     = 1 << (ADC_W - 1);
  localparam int EXP_FLT_W = 18;
  localparam int EXP_FLT_A = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_ACC
  } flt_state_t;

  // Runtime configuration sampled at frame capture.
  typedef struct packed {
    logic [EXP_FLT_W-1:0] coef_a;
    logic                 bypass;
  } exp_flt_cfg_t;

  // Packed frame types at the default parameters, channel 0 in the LSBs.
  typedef logic [ADC_N*ADC_W-1:0]     adc_data_t;
  typedef logic [ADC_N*EXP_FLT_W-1:0] flt_data_t;

  // Width of a channel index; at least one bit so a single-channel build works.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exp_flt_core.sv
// exp_flt_core
// Arithmetic slot shared by all channels of exp_flt_mch.
//   d     = x - y                         (combinational, OUT_W+1 bits)
//   p_reg = d * coef                      (registered when mul_en)
//   y_acc = y + ((p_reg + 2^(COEF_W-1)) >>> COEF_W)   (round half up)
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   mul_en     load the product register (MUL step of the owning FSM)
//   x, y       input sample and current state of the selected channel
//   coef       unsigned coefficient
//   y_acc      updated state for the selected channel
module exp_flt_core
  import exp_flt_mch_pkg::*;
#(
  parameter int OUT_W  = EXP_FLT_W,
  parameter int COEF_W = EXP_FLT_A
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     mul_en,
  input  logic signed [OUT_W-1:0]  x,
  input  logic signed [OUT_W-1:0]  y,
  input  logic        [COEF_W-1:0] coef,
  output logic signed [OUT_W-1:0]  y_acc
);

  localparam int D_W = OUT_W + 1;
  localparam int P_W = OUT_W + COEF_W + 1;
  localparam logic signed [P_W-1:0] HALF = P_W'(1) << (COEF_W - 1);

  logic signed [D_W-1:0] d;
  logic signed [P_W-1:0] p_next;
  logic signed [P_W-1:0] p_reg;
  logic signed [P_W-1:0] p_rnd;
  logic signed [D_W-1:0] sum;
  logic                  unused_bits;

  assign d = D_W'(x) - D_W'(y);

  // |d| < 2^OUT_W and coef < 2^COEF_W, so the product fits in P_W bits.
  assign p_next = P_W'(d) * P_W'($signed({1'b0, coef}));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_reg <= '0;
    end else if (mul_en) begin
      p_reg <= p_next;
    end
  end

  // The top D_W bits of the rounded product are the arithmetic shift by COEF_W.
  assign p_rnd = p_reg + HALF;
  assign sum   = D_W'(y) + p_rnd[P_W-1:COEF_W];

  // The step never carries y outside [old y, x], so the result fits in OUT_W.
  assign y_acc       = sum[OUT_W-1:0];
  assign unused_bits = ^{sum[OUT_W], p_rnd[COEF_W-1:0]};

endmodule

// File: rtl/exp_flt_mch.sv
// exp_flt_mch
// Multi-channel first-order exponential low-pass filter, y += A*(x - y), with
// one time-shared multiplier. Each frame walks MUL/ACC once per channel.
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   ce         clock enable for the FSM, product and state registers
//   init       synchronous clear of y, ovr and the FSM (highest priority)
//   coef_a     coefficient, sampled at frame capture
//   bypass     sampled at capture; frame loads y = x directly
//   in_data    packed offset-binary samples, channel 0 in the LSBs
//   in_val     frame valid pulse
//   out_data   packed signed filter states (live y registers)
//   out_val    one-cycle frame-done pulse
//   busy       high from capture until the final ACC
//   ovr        sticky overrun (frame offered while busy)
module exp_flt_mch
  import exp_flt_mch_pkg::*;
#(
  parameter int N_CH          = ADC_N,
  parameter int IN_W          = ADC_W,
  parameter int OUT_W         = EXP_FLT_W,
  parameter int COEF_W        = EXP_FLT_A,
  parameter int PRELOAD_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   ce,
  input  logic                   init,
  input  logic [COEF_W-1:0]      coef_a,
  input  logic                   bypass,
  input  logic [N_CH*IN_W-1:0]   in_data,
  input  logic                   in_val,
  output logic [N_CH*OUT_W-1:0]  out_data,
  output logic                   out_val,
  output logic                   busy,
  output logic                   ovr
);

  localparam int              CH_W    = ch_bits(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  flt_state_t              state_reg, state_next;
  logic [CH_W-1:0]         ch_reg;
  logic [COEF_W-1:0]       coef_reg;
  logic                    bypass_reg;
  logic                    first_reg;
  logic                    out_val_reg;
  logic                    busy_reg;
  logic                    ovr_reg;

  logic                    capture, mul_en, acc_en, last_acc, load_direct;
  logic signed [OUT_W-1:0] x_bank [N_CH];
  logic signed [OUT_W-1:0] y_bank [N_CH];
  logic signed [OUT_W-1:0] x_cur, y_cur, y_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    mul_en     = 1'b0;
    acc_en     = 1'b0;
    last_acc   = 1'b0;
    if (ce) begin
      case (state_reg)
        ST_IDLE: begin
          if (in_val) begin
            capture    = 1'b1;
            state_next = ST_MUL;
          end
        end
        ST_MUL: begin
          mul_en     = 1'b1;
          state_next = ST_ACC;
        end
        ST_ACC: begin
          acc_en = 1'b1;
          if (ch_reg == LAST_CH) begin
            last_acc   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_MUL;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    // init aborts any frame and swallows a coincident in_val.
    if (init) begin
      state_next = ST_IDLE;
      capture    = 1'b0;
      mul_en     = 1'b0;
      acc_en     = 1'b0;
      last_acc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_reg      <= '0;
      coef_reg    <= '0;
      bypass_reg  <= 1'b0;
      first_reg   <= 1'b1;
      out_val_reg <= 1'b0;
      busy_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      // out_val is a pulse: it drops on the next clk whatever ce does.
      out_val_reg <= 1'b0;
      if (init) begin
        ch_reg    <= '0;
        busy_reg  <= 1'b0;
        ovr_reg   <= 1'b0;
        first_reg <= 1'b1;
      end else begin
        // busy is still high during the final ACC, so a frame offered then
        // is dropped as an overrun too.
        if (in_val && busy_reg) begin
          ovr_reg <= 1'b1;
        end
        if (capture) begin
          coef_reg   <= coef_a;
          bypass_reg <= bypass;
          ch_reg     <= '0;
          busy_reg   <= 1'b1;
        end
        if (acc_en) begin
          if (last_acc) begin
            out_val_reg <= 1'b1;
            busy_reg    <= 1'b0;
            first_reg   <= 1'b0;
          end else begin
            ch_reg <= ch_reg + CH_W'(1);
          end
        end
      end
    end
  end

  assign load_direct = bypass_reg || ((PRELOAD_FIRST != 0) && first_reg);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic signed [OUT_W-1:0] x_s;
      logic signed [OUT_W-1:0] x_reg;
      logic signed [OUT_W-1:0] y_reg;

      // Offset-binary to two's complement is an MSB flip; then left-align.
      assign x_s = {~in_data[gi*IN_W + IN_W - 1], in_data[gi*IN_W +: IN_W - 1],
                    {(OUT_W - IN_W){1'b0}}};

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          x_reg <= '0;
          y_reg <= '0;
        end else begin
          if (capture) begin
            x_reg <= x_s;
          end
          if (init) begin
            y_reg <= '0;
          end else if (acc_en && (ch_reg == CH_W'(gi))) begin
            y_reg <= load_direct ? x_reg : y_acc;
          end
        end
      end

      assign x_bank[gi]                  = x_reg;
      assign y_bank[gi]                  = y_reg;
      assign out_data[gi*OUT_W +: OUT_W] = y_reg;
    end
  endgenerate

  assign x_cur = x_bank[ch_reg];
  assign y_cur = y_bank[ch_reg];

  exp_flt_core #(
    .OUT_W  (OUT_W),
    .COEF_W (COEF_W)
  ) u_core (
    .clk    (clk),
    .rstn   (rstn),
    .mul_en (mul_en),
    .x      (x_cur),
    .y      (y_cur),
    .coef   (coef_reg),
    .y_acc  (y_acc)
  );

  assign out_val = out_val_reg;
  assign busy    = busy_reg;
  assign ovr     = ovr_reg;

endmodule

// File: tb/tb_exp_flt_mch.sv
// tb_exp_flt_mch
// Directed bench for exp_flt_mch at default parameters, plus a second instance
// with PRELOAD_FIRST=1 that sees the same stimulus.
module tb_exp_flt_mch;

  localparam int N_CH   = 2;
  localparam int IN_W   = 12;
  localparam int OUT_W  = 18;
  localparam int COEF_W = 18;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  ce;
  logic                  init;
  logic [COEF_W-1:0]     coef_a;
  logic                  bypass;
  logic [N_CH*IN_W-1:0]  in_data;
  logic                  in_val;
  logic [N_CH*OUT_W-1:0] out_data, out_data_p;
  logic                  out_val, out_val_p;
  logic                  busy, busy_p;
  logic                  ovr, ovr_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exp_flt_mch dut (
    .clk(clk), .rstn(rstn), .ce(ce), .init(init), .coef_a(coef_a),
    .bypass(bypass), .in_data(in_data), .in_val(in_val),
    .out_data(out_data), .out_val(out_val), .busy(busy), .ovr(ovr)
  );

  exp_flt_mch #(.PRELOAD_FIRST(1)) dut_p (
    .clk(clk), .rstn(rstn), .ce(ce), .init(init), .coef_a(coef_a),
    .bypass(bypass), .in_data(in_data), .in_val(in_val),
    .out_data(out_data_p), .out_val(out_val_p), .busy(busy_p), .ovr(ovr_p)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] yv(input int k);
    return 64'($signed(out_data[k*OUT_W +: OUT_W]));
  endfunction

  function automatic logic signed [63:0] ypv(input int k);
    return 64'($signed(out_data_p[k*OUT_W +: OUT_W]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic start_frame(input logic [IN_W-1:0] a0, input logic [IN_W-1:0] a1,
                             input logic [COEF_W-1:0] c, input logic b);
    in_data = {a1, a0};
    coef_a  = c;
    bypass  = b;
    in_val  = 1'b1;
    tick();
    in_val  = 1'b0;
  endtask

  // Ticks n cycles and returns how many had out_val high.
  task automatic count_out(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (out_val === 1'b1) pulses++;
    end
  endtask

  task automatic frame(input string tag, input logic [IN_W-1:0] a0,
                       input logic [IN_W-1:0] a1, input logic [COEF_W-1:0] c,
                       input logic b, input int exp_lat, input logic toggle,
                       input int e0, input int e1);
    int n;
    start_frame(a0, a1, c, b);
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    n = 0;
    while (out_val !== 1'b1 && n < 30) begin
      if (toggle) ce = ~ce;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_y0"}, yv(0), 64'(e0));
    chk({tag, "_y1"}, yv(1), 64'(e1));
    $display("frame %s lat=%0d y0=%0d y1=%0d yp0=%0d yp1=%0d", tag, n, yv(0), yv(1),
             ypv(0), ypv(1));
    // Pulse must drop on the next clk even with ce low.
    ce = toggle ? 1'b0 : 1'b1;
    tick();
    chk({tag, "_pulse"}, 64'(out_val), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    ce = 1'b1;
  endtask

  initial begin
    int pulses;
    rstn = 1'b0; ce = 1'b1; init = 1'b0; coef_a = '0; bypass = 1'b0;
    in_data = '0; in_val = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_y0", yv(0), 64'(0));
    chk("rst_y1", yv(1), 64'(0));
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovr", 64'(ovr), 64'(0));
    chk("rst_p_busy_ovr", 64'({busy_p, ovr_p, out_val_p}), 64'(0));
    rstn = 1'b1;
    tick();

    // Step response, A = 0.5
    frame("step1", 12'd4095, 12'd0, 18'h20000, 1'b0, 4, 1'b0, 65504, -65536);
    chk("pre1_y0", ypv(0), 64'(131008));
    chk("pre1_y1", ypv(1), 64'(-131072));
    frame("step2", 12'd4095, 12'd0, 18'h20000, 1'b0, 4, 1'b0, 98256, -98304);

    // Bypass loads x directly
    do_init();
    chk("init_y0", yv(0), 64'(0));
    frame("bypass", 12'd4095, 12'd0, 18'h20000, 1'b1, 4, 1'b0, 131008, -131072);

    // Preload on the first frame after init, then normal filtering
    do_init();
    frame("pre_f1", 12'd4095, 12'd0, 18'h20000, 1'b0, 4, 1'b0, 65504, -65536);
    chk("pre_f1_y0", ypv(0), 64'(131008));
    chk("pre_f1_y1", ypv(1), 64'(-131072));
    frame("pre_f2", 12'd2048, 12'd0, 18'h20000, 1'b0, 4, 1'b0, 32752, -98304);
    chk("pre_f2_y0", ypv(0), 64'(65504));
    chk("pre_f2_y1", ypv(1), 64'(-131072));

    // Rounding: drive y0 to -1, then round half up back to 0, then tiny step
    do_init();
    frame("rnd_neg1", 12'd2047, 12'd2048, 18'd4096, 1'b0, 4, 1'b0, -1, 0);
    frame("rnd_half", 12'd2048, 12'd2048, 18'h20000, 1'b0, 4, 1'b0, 0, 0);
    frame("rnd_tiny", 12'd2047, 12'd2048, 18'd1, 1'b0, 4, 1'b0, 0, 0);

    // Overrun two clocks after capture
    do_init();
    chk("ovr_clr0", 64'(ovr), 64'(0));
    start_frame(12'd4095, 12'd0, 18'h20000, 1'b0);
    tick();
    in_data = {12'd4095, 12'd0};
    in_val  = 1'b1;
    tick();
    in_val  = 1'b0;
    chk("ovr_set", 64'(ovr), 64'(1));
    count_out(10, pulses);
    chk("ovr_one_out", 64'(pulses), 64'(1));
    chk("ovr_y0", yv(0), 64'(65504));
    chk("ovr_y1", yv(1), 64'(-65536));
    $display("overrun mid-frame ovr=%0d pulses=%0d y0=%0d y1=%0d", ovr, pulses, yv(0), yv(1));

    // Frame offered during the final ACC is an overrun
    do_init();
    chk("init_ovr", 64'(ovr), 64'(0));
    chk("init_y1", yv(1), 64'(0));
    start_frame(12'd4095, 12'd0, 18'h20000, 1'b0);
    tick(); tick(); tick();
    in_val = 1'b1;
    tick();
    in_val = 1'b0;
    chk("lastacc_out", 64'(out_val), 64'(1));
    chk("lastacc_ovr", 64'(ovr), 64'(1));
    count_out(8, pulses);
    chk("lastacc_drop", 64'(pulses), 64'(0));
    $display("overrun final-acc ovr=%0d extra_pulses=%0d", ovr, pulses);

    // init together with in_val: dropped without ovr
    init = 1'b1; in_val = 1'b1;
    tick();
    init = 1'b0; in_val = 1'b0;
    chk("init_val_busy", 64'(busy), 64'(0));
    chk("init_val_ovr", 64'(ovr), 64'(0));
    count_out(8, pulses);
    chk("init_val_none", 64'(pulses), 64'(0));
    $display("init+in_val busy=%0d ovr=%0d pulses=%0d", busy, ovr, pulses);

    // ce toggling every clock
    frame("ce_tog", 12'd4095, 12'd0, 18'h20000, 1'b0, 8, 1'b1, 65504, -65536);

    // Async reset mid-frame, after MUL of ch1
    do_init();
    start_frame(12'd4095, 12'd0, 18'h20000, 1'b0);
    tick(); tick(); tick();
    chk("mid_y0", yv(0), 64'(65504));
    rstn = 1'b0;
    #1;
    chk("arst_y0", yv(0), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    tick();
    rstn = 1'b1;
    count_out(8, pulses);
    chk("arst_none", 64'(pulses), 64'(0));
    $display("async reset mid-frame y0=%0d pulses=%0d", yv(0), pulses);

    // init mid-frame aborts; next frame acts as the first
    start_frame(12'd4095, 12'd0, 18'h20000, 1'b0);
    tick(); tick();
    do_init();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_y0", yv(0), 64'(0));
    count_out(8, pulses);
    chk("abort_none", 64'(pulses), 64'(0));
    $display("init mid-frame busy=%0d y0=%0d pulses=%0d", busy, yv(0), pulses);
    frame("after_abort", 12'd4095, 12'd0, 18'h20000, 1'b0, 4, 1'b0, 65504, -65536);
    chk("after_abort_p", ypv(0), 64'(131008));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
